maskmul_seq_ctrl: RTL
=====================

Name: maskmul_seq_ctrl

Overview:
Sequencing controller that sits in front of the maskmul datapath and shares nothing else with it.
- Accepts unmasked operand pairs over a valid/ready handshake.
- Draws fresh masks from an internal LFSR, drives the masked shares and masks into maskmul, and waits the datapath latency.
- Unmasks qm and returns the plain result over a second valid/ready handshake.
- One operation in flight at a time.

Parameters:
W, 2, operand/share width in bits; legal range 1..5 (3*W <= 16).
MUL_LAT, 2, rising edges from operand acceptance to the edge at which qm is valid; legal range 1..15.
SEED, 16'hACE1, LFSR reset value; SEED=0 is replaced by 16'hACE1.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
in_valid  in  1  operand pair a/b valid.
in_ready  out  1  controller can accept an operand pair.
a  in  W  unmasked operand A.
b  in  W  unmasked operand B.
am  out  W  masked share to datapath, a^ma.
bm  out  W  masked share to datapath, b^mb.
ma  out  W  mask for A.
mb  out  W  mask for B.
mq  out  W  output mask.
qm  in  W  masked product from datapath.
out_valid  out  1  result q valid.
out_ready  in  1  consumer accepts q.
q  out  W  unmasked result, qm^mq.
busy  out  1  high in any state other than IDLE.
ops_count  out  16  completed operations; wraps FFFF->0000.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - am, bm, ma, mb, mq, q, out_valid, busy, ops_count, wait counter = 0.
  - LFSR = SEED.
  - in_ready=1 once reset releases.
  - Reset mid-operation abandons the operation; no result is produced.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1 (right shift, XOR mask 16'hB400).
  - Free-running: advances every clock while not in reset.
- Masks at acceptance: ma=lfsr[W-1:0], mb=lfsr[2W-1:W], mq=lfsr[3W-1:2W], using the LFSR value before that edge's update.
- State IDLE:
  - in_ready=1, busy=0.
  - On an edge with in_valid=1: register ma/mb/mq, am=a^ma, bm=b^mb; load wait counter with MUL_LAT; go to WAIT.
- State WAIT:
  - in_ready=0, busy=1; counter decrements each edge.
  - am/bm/ma/mb/mq are held stable throughout WAIT.
  - At the MUL_LAT-th edge after acceptance: q<=qm^mq, out_valid<=1, go to DONE.
  - MUL_LAT=1 means the edge immediately after acceptance.
- State DONE:
  - in_ready=0, busy=1; q and out_valid held until out_ready=1.
  - On the handshake edge: out_valid<=0, ops_count<=ops_count+1, go to IDLE.
  - am/bm/ma/mb/mq stay at their last values until the next acceptance.
- Request timing:
  - in_valid while in_ready=0 is ignored; no queuing.
  - A new request can be accepted no earlier than the edge after the output handshake.
  - Minimum period per operation is MUL_LAT+2 cycles.
- Unknown inputs: X/Z on out_ready in DONE is a protocol violation; behaviour is undefined.
- Verification stub: a behavioural model qm = mq ^ ((am^ma) & (bm^mb)) gives q = a & b and is used as the bench datapath.

Test Plan:
- Reset values: hold reset=0 for 3 cycles with random inputs -> all outputs 0 and in_ready=0 during reset; after release in_ready=1, busy=0, ops_count=0.
- Single operation: W=2, MUL_LAT=2, stub datapath; a=2'b11, b=2'b10 accepted at edge t0 -> am^ma=2'b11 and bm^mb=2'b10 from t0; out_valid=1 and q=2'b10 after edge t0+2; with out_ready=1, out_valid=0 after t0+3 and ops_count=1.
- Backpressure and ignored requests: out_ready=0 for 5 cycles in DONE while in_valid=1 with a/b toggling -> q, am, bm constant; in_ready=0; no second acceptance. Release out_ready -> exactly one completion, ops_count increments by 1.
- Mask sequence: SEED=16'hACE1, a=b=0 accepted in the first cycle after reset release -> ma=2'b01, mb=2'b00, mq=2'b10 (lfsr[5:0] of 16'hACE1). Ten back-to-back operations give mask triples matching the reference LFSR model.
- Reset mid-WAIT: reset=0 one cycle after acceptance (MUL_LAT=4) -> immediate IDLE and zeroed outputs; no out_valid pulse; ops_count=0; next operation after release completes correctly.
- Boundaries: MUL_LAT=1 gives q one edge after acceptance. Preload 65535 completions via 65535 operations (or force) -> next completion gives ops_count=0000.

Source files
------------

// File: rtl/maskmul_seq_ctrl.sv
// maskmul_seq_ctrl
//   Sequencing controller in front of the masked-multiply datapath. Accepts an
//   unmasked operand pair, draws fresh masks from a free-running LFSR, drives
//   the masked shares and masks to the datapath, waits MUL_LAT edges, then
//   unmasks qm and returns the plain result. One operation in flight.
// Ports
//   clock, reset        : rising-edge clock, async active-low reset
//   in_valid/in_ready   : operand handshake for a, b
//   am, bm, ma, mb, mq  : masked shares and masks to the datapath
//   qm                  : masked product from the datapath
//   out_valid/out_ready : result handshake for q
//   busy                : controller not idle
//   ops_count           : completed operations (wraps)
module maskmul_seq_ctrl #(
  parameter int          W       = 2,
  parameter int          MUL_LAT = 2,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] am,
  output logic [W-1:0] bm,
  output logic [W-1:0] ma,
  output logic [W-1:0] mb,
  output logic [W-1:0] mq,
  input  logic [W-1:0] qm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic         busy,
  output logic [15:0]  ops_count
);

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [15:0] lfsr, lfsr_nx;
  logic        accept, wait_end, handshake;

  // Galois form, right shift; feedback taps x^16+x^14+x^13+x^11+1.
  assign lfsr_nx   = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

  assign accept    = (state == S_IDLE) && in_valid;
  // cnt is loaded with MUL_LAT at acceptance, so cnt==1 marks the
  // MUL_LAT-th edge after acceptance.
  assign wait_end  = (state == S_WAIT) && (cnt == 4'd1);
  assign handshake = (state == S_DONE) && out_ready;

  // in_ready is gated by reset so it reads 0 while reset is asserted.
  assign in_ready  = (state == S_IDLE) && reset;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept)    state_nx = S_WAIT;
      S_WAIT:  if (wait_end)  state_nx = S_DONE;
      S_DONE:  if (handshake) state_nx = S_IDLE;
      default:                state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr      <= SEED_EFF;
      cnt       <= '0;
      am        <= '0;
      bm        <= '0;
      ma        <= '0;
      mb        <= '0;
      mq        <= '0;
      q         <= '0;
      out_valid <= 1'b0;
      ops_count <= '0;
    end else begin
      lfsr <= lfsr_nx;
      if (accept) begin
        // Masks come from the pre-update LFSR value.
        ma  <= lfsr[W-1:0];
        mb  <= lfsr[2*W-1:W];
        mq  <= lfsr[3*W-1:2*W];
        am  <= a ^ lfsr[W-1:0];
        bm  <= b ^ lfsr[2*W-1:W];
        cnt <= 4'(MUL_LAT);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (wait_end) begin
        q         <= qm ^ mq;
        out_valid <= 1'b1;
      end
      if (handshake) begin
        out_valid <= 1'b0;
        ops_count <= ops_count + 16'd1;
      end
    end
  end

endmodule
